// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the pipeline hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int TNEW_W = 3;
    localparam logic [TNEW_W-1:0] TNEW_NEVER = 3'b111;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    typedef struct packed {
        logic [4:0]        dst;
        logic              rfwr;
        logic [TNEW_W-1:0] tnew;
    } writer_t;

    // The E entry also remembers its own sources so E-stage forwarding can be resolved.
    typedef struct packed {
        writer_t    wr;
        logic [4:0] rs;
        logic [4:0] rt;
    } e_entry_t;

    localparam writer_t  WRITER_BUBBLE = '{dst: 5'd0, rfwr: 1'b0, tnew: TNEW_NEVER};
    localparam e_entry_t E_BUBBLE      = '{wr: WRITER_BUBBLE, rs: 5'd0, rt: 5'd0};

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
        if (x == TNEW_NEVER || x == '0) return x;
        return x - 3'd1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Compares one source register against the E/M/W writers; youngest live match decides.
module hazard_match
    import hazard_scoreboard_pkg::*;
(
    input  logic [4:0] src,
    input  logic [2:0] tuse,
    input  logic [4:0] e_dst,
    input  logic       e_rfwr,
    input  logic [2:0] e_tnew,
    input  logic [4:0] m_dst,
    input  logic       m_rfwr,
    input  logic [2:0] m_tnew,
    input  logic [4:0] w_dst,
    input  logic       w_rfwr,
    input  logic [2:0] w_tnew,
    output logic       stall,
    output logic [1:0] fwd
);

    logic       hit_e, hit_m, hit_w;
    logic       hit;
    logic [2:0] tnew_sel;
    logic [1:0] code_sel;

    // Register 0 can never match since a live entry requires a nonzero dst.
    assign hit_e = e_rfwr && (e_dst != 5'd0) && (e_dst == src);
    assign hit_m = m_rfwr && (m_dst != 5'd0) && (m_dst == src);
    assign hit_w = w_rfwr && (w_dst != 5'd0) && (w_dst == src);

    always_comb begin
        hit      = 1'b0;
        tnew_sel = TNEW_NEVER;
        code_sel = FWD_RF;
        if (hit_e) begin
            hit      = 1'b1;
            tnew_sel = e_tnew;
            code_sel = FWD_E;
        end else if (hit_m) begin
            hit      = 1'b1;
            tnew_sel = m_tnew;
            code_sel = FWD_M;
        end else if (hit_w) begin
            hit      = 1'b1;
            tnew_sel = w_tnew;
            code_sel = FWD_W;
        end
    end

    assign stall = hit && (tuse != TNEW_NEVER) && (tnew_sel > tuse);
    assign fwd   = (hit && tnew_sel == 3'd0) ? code_sel : FWD_RF;

endmodule

// File: rtl/hazard_scoreboard.sv
// Three-entry E/M/W writer scoreboard producing D stall and D/E forwarding selects.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic [2:0]  tuse_rs_d,
    input  logic [2:0]  tuse_rt_d,
    input  logic [4:0]  dst_d,
    input  logic        rfwr_d,
    input  logic [2:0]  tnew_d,
    output logic        stall,
    output logic [1:0]  fwd_rs_d,
    output logic [1:0]  fwd_rt_d,
    output logic [1:0]  fwd_rs_e,
    output logic [1:0]  fwd_rt_e,
    output logic [31:0] stall_cnt
);

    e_entry_t e_q;
    writer_t  m_q;
    writer_t  w_q;

    logic stall_rs, stall_rt;
    logic stall_rs_e_unused, stall_rt_e_unused;

    hazard_match u_rs_d (
        .src(rs_d), .tuse(tuse_rs_d),
        .e_dst(e_q.wr.dst), .e_rfwr(e_q.wr.rfwr), .e_tnew(e_q.wr.tnew),
        .m_dst(m_q.dst), .m_rfwr(m_q.rfwr), .m_tnew(m_q.tnew),
        .w_dst(w_q.dst), .w_rfwr(w_q.rfwr), .w_tnew(w_q.tnew),
        .stall(stall_rs), .fwd(fwd_rs_d)
    );

    hazard_match u_rt_d (
        .src(rt_d), .tuse(tuse_rt_d),
        .e_dst(e_q.wr.dst), .e_rfwr(e_q.wr.rfwr), .e_tnew(e_q.wr.tnew),
        .m_dst(m_q.dst), .m_rfwr(m_q.rfwr), .m_tnew(m_q.tnew),
        .w_dst(w_q.dst), .w_rfwr(w_q.rfwr), .w_tnew(w_q.tnew),
        .stall(stall_rt), .fwd(fwd_rt_d)
    );

    // E-stage operands only look at older stages, so the E slot is fed a bubble.
    hazard_match u_rs_e (
        .src(e_q.rs), .tuse(TNEW_NEVER),
        .e_dst(WRITER_BUBBLE.dst), .e_rfwr(WRITER_BUBBLE.rfwr), .e_tnew(WRITER_BUBBLE.tnew),
        .m_dst(m_q.dst), .m_rfwr(m_q.rfwr), .m_tnew(m_q.tnew),
        .w_dst(w_q.dst), .w_rfwr(w_q.rfwr), .w_tnew(w_q.tnew),
        .stall(stall_rs_e_unused), .fwd(fwd_rs_e)
    );

    hazard_match u_rt_e (
        .src(e_q.rt), .tuse(TNEW_NEVER),
        .e_dst(WRITER_BUBBLE.dst), .e_rfwr(WRITER_BUBBLE.rfwr), .e_tnew(WRITER_BUBBLE.tnew),
        .m_dst(m_q.dst), .m_rfwr(m_q.rfwr), .m_tnew(m_q.tnew),
        .w_dst(w_q.dst), .w_rfwr(w_q.rfwr), .w_tnew(w_q.tnew),
        .stall(stall_rt_e_unused), .fwd(fwd_rt_e)
    );

    assign stall = stall_rs || stall_rt;

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q       <= E_BUBBLE;
            m_q       <= WRITER_BUBBLE;
            w_q       <= WRITER_BUBBLE;
            stall_cnt <= 32'd0;
        end else begin
            w_q <= '{dst: m_q.dst, rfwr: m_q.rfwr, tnew: sat_dec(m_q.tnew)};
            m_q <= '{dst: e_q.wr.dst, rfwr: e_q.wr.rfwr, tnew: sat_dec(e_q.wr.tnew)};
            if (stall) begin
                e_q <= E_BUBBLE;
            end else begin
                e_q <= '{wr: '{dst: dst_d, rfwr: rfwr_d, tnew: tnew_d}, rs: rs_d, rt: rt_d};
            end
            if (stall && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scenarios plus randomized traffic checked against an instruction-history model.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_d, rt_d, dst_d;
    logic [2:0]  tuse_rs_d, tuse_rt_d, tnew_d;
    logic        rfwr_d;
    logic        stall;
    logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic [31:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset),
        .rs_d(rs_d), .rt_d(rt_d),
        .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
        .dst_d(dst_d), .rfwr_d(rfwr_d), .tnew_d(tnew_d),
        .stall(stall),
        .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Model: every instruction that entered E, tagged with the cycle it sat in E.
    typedef struct {
        logic [4:0] dst;
        logic       rfwr;
        logic [2:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
        int         issue;
    } rec_t;

    rec_t        hist[$];
    int          cyc   = 0;
    logic [31:0] m_cnt = 0;

    function automatic logic [2:0] aged(input logic [2:0] t, input int age);
        if (t == 3'd7) return t;
        if (int'(t) > age) return 3'(int'(t) - age);
        return 3'd0;
    endfunction

    function automatic void lookup(input logic [4:0] s, input int min_age,
                                   output bit hit, output logic [2:0] t, output logic [1:0] code);
        hit = 0; t = 3'd7; code = 2'd0;
        if (s == 5'd0) return;
        for (int a = min_age; a <= 2 && !hit; a++) begin
            foreach (hist[i]) begin
                if (hist[i].issue == cyc - a && hist[i].rfwr && hist[i].dst == s) begin
                    hit = 1; t = aged(hist[i].tnew, a); code = 2'(a + 1);
                end
            end
        end
    endfunction

    function automatic void exp_d(input logic [4:0] s, input logic [2:0] tuse,
                                  output bit st, output logic [1:0] fw);
        bit hit; logic [2:0] t; logic [1:0] code;
        lookup(s, 0, hit, t, code);
        st = hit && tuse != 3'd7 && t > tuse;
        fw = (hit && t == 3'd0) ? code : 2'd0;
    endfunction

    function automatic logic [1:0] exp_e(input bit rs_side);
        bit hit; logic [2:0] t; logic [1:0] code; logic [4:0] s;
        s = 5'd0;
        foreach (hist[i]) if (hist[i].issue == cyc) s = rs_side ? hist[i].rs : hist[i].rt;
        lookup(s, 1, hit, t, code);
        return (hit && t == 3'd0) ? code : 2'd0;
    endfunction

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [2:0] trs, input logic [2:0] trt,
                         input logic [4:0] dst, input logic rf, input logic [2:0] tn);
        rs_d = rs; rt_d = rt; tuse_rs_d = trs; tuse_rt_d = trt;
        dst_d = dst; rfwr_d = rf; tnew_d = tn;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 3'd7, 3'd7, 5'd0, 1'b0, 3'd7);
    endtask

    task automatic tick();
        bit s1, s2; logic [1:0] f1, f2;
        exp_d(rs_d, tuse_rs_d, s1, f1);
        exp_d(rt_d, tuse_rt_d, s2, f2);
        @(posedge clk);
        cyc++;
        if (reset) begin
            hist.delete();
            m_cnt = 0;
        end else begin
            if (!(s1 || s2)) hist.push_back('{dst_d, rfwr_d, tnew_d, rs_d, rt_d, cyc});
            else if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        end
        while (hist.size() > 4) void'(hist.pop_front());
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1; idle();
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            #1;
            n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall c%0d: got %0b want 0", i, stall); end
            n_cmp++; if ({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e} !== 8'd0) begin
                n_err++; $display("FAIL rst_fwd c%0d: got %02h want 00", i, {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e}); end
            n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL rst_cnt c%0d: got %0d want 0", i, stall_cnt); end
            tick();
        end
    endtask

    task automatic test_load_use();
        reset_dut();
        drive(5'd0, 5'd0, 3'd7, 3'd7, 5'd8, 1'b1, 3'd2);     // lw $8
        tick();
        drive(5'd8, 5'd0, 3'd1, 3'd7, 5'd10, 1'b1, 3'd1);    // add $10,$8
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall1: got %0b want 1", stall); end
        tick();
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_stall2: got %0b want 0", stall); end
        tick();
        idle(); #1;
        n_cmp++; if (fwd_rs_e !== 2'd3) begin n_err++; $display("FAIL lu_fwd_rs_e: got %0d want 3", fwd_rs_e); end
        n_cmp++; if (stall_cnt !== 32'd1) begin n_err++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
    endtask

    task automatic test_load_branch();
        reset_dut();
        drive(5'd0, 5'd0, 3'd7, 3'd7, 5'd8, 1'b1, 3'd2);
        tick();
        drive(5'd8, 5'd0, 3'd0, 3'd0, 5'd0, 1'b0, 3'd7);     // beq $8,$0
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lb_stall1: got %0b want 1", stall); end
        tick();
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lb_stall2: got %0b want 1", stall); end
        tick();
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lb_stall3: got %0b want 0", stall); end
        n_cmp++; if (fwd_rs_d !== 2'd3) begin n_err++; $display("FAIL lb_fwd_rs_d: got %0d want 3", fwd_rs_d); end
        n_cmp++; if (stall_cnt !== 32'd2) begin n_err++; $display("FAIL lb_cnt: got %0d want 2", stall_cnt); end
        tick();
    endtask

    task automatic test_alu_fwd();
        reset_dut();
        drive(5'd1, 5'd2, 3'd1, 3'd1, 5'd9, 1'b1, 3'd1);     // add $9
        tick();
        drive(5'd9, 5'd0, 3'd1, 3'd7, 5'd11, 1'b1, 3'd1);    // ori $11,$9
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_stall: got %0b want 0", stall); end
        tick();
        idle(); #1;
        n_cmp++; if (fwd_rs_e !== 2'd2) begin n_err++; $display("FAIL alu_fwd_rs_e: got %0d want 2", fwd_rs_e); end
        n_cmp++; if (fwd_rt_e !== 2'd0) begin n_err++; $display("FAIL alu_fwd_rt_e: got %0d want 0", fwd_rt_e); end
    endtask

    task automatic test_jal_jr();
        reset_dut();
        drive(5'd0, 5'd0, 3'd7, 3'd7, 5'd31, 1'b1, 3'd0);    // jal
        tick();
        drive(5'd31, 5'd31, 3'd0, 3'd0, 5'd0, 1'b0, 3'd7);   // jr $31 (rt also probes $31)
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL jr_stall: got %0b want 0", stall); end
        n_cmp++; if (fwd_rs_d !== 2'd1) begin n_err++; $display("FAIL jr_fwd_rs_d: got %0d want 1", fwd_rs_d); end
        n_cmp++; if (fwd_rt_d !== 2'd1) begin n_err++; $display("FAIL jr_fwd_rt_d: got %0d want 1", fwd_rt_d); end
        tick();
    endtask

    task automatic test_zero_reg();
        reset_dut();
        drive(5'd0, 5'd0, 3'd7, 3'd7, 5'd0, 1'b1, 3'd2);     // lw $0
        tick();
        drive(5'd0, 5'd0, 3'd0, 3'd0, 5'd3, 1'b1, 3'd1);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL zero_stall: got %0b want 0", stall); end
        n_cmp++; if ({fwd_rs_d, fwd_rt_d} !== 4'd0) begin n_err++; $display("FAIL zero_fwd_d: got %0h want 0", {fwd_rs_d, fwd_rt_d}); end
        tick();
        idle(); #1;
        n_cmp++; if ({fwd_rs_e, fwd_rt_e} !== 4'd0) begin n_err++; $display("FAIL zero_fwd_e: got %0h want 0", {fwd_rs_e, fwd_rt_e}); end
    endtask

    task automatic test_reset_mid_stall();
        reset_dut();
        drive(5'd0, 5'd0, 3'd7, 3'd7, 5'd8, 1'b1, 3'd2);
        tick();
        drive(5'd8, 5'd0, 3'd1, 3'd7, 5'd10, 1'b1, 3'd1);
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rms_pre: got %0b want 1", stall); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rms_stall: got %0b want 0", stall); end
        n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL rms_cnt: got %0d want 0", stall_cnt); end
        tick();
        idle(); #1;
        n_cmp++; if (fwd_rs_e !== 2'd0) begin n_err++; $display("FAIL rms_fwd_rs_e: got %0d want 0", fwd_rs_e); end
    endtask

    function automatic logic [2:0] rand_tuse();
        case ($urandom_range(0, 3))
            0: return 3'd0;
            1: return 3'd1;
            2: return 3'd2;
            default: return 3'd7;
        endcase
    endfunction

    task automatic test_random();
        bit s1, s2; logic [1:0] f1, f2, fe_rs, fe_rt;
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), rand_tuse(), rand_tuse(),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)));
            #1;
            exp_d(rs_d, tuse_rs_d, s1, f1);
            exp_d(rt_d, tuse_rt_d, s2, f2);
            fe_rs = exp_e(1'b1);
            fe_rt = exp_e(1'b0);
            n_cmp++; if (stall !== (s1 || s2)) begin n_err++; $display("FAIL rnd_stall c%0d: got %0b want %0b", i, stall, s1 || s2); end
            n_cmp++; if (fwd_rs_d !== f1) begin n_err++; $display("FAIL rnd_fwd_rs_d c%0d: got %0d want %0d", i, fwd_rs_d, f1); end
            n_cmp++; if (fwd_rt_d !== f2) begin n_err++; $display("FAIL rnd_fwd_rt_d c%0d: got %0d want %0d", i, fwd_rt_d, f2); end
            n_cmp++; if (fwd_rs_e !== fe_rs) begin n_err++; $display("FAIL rnd_fwd_rs_e c%0d: got %0d want %0d", i, fwd_rs_e, fe_rs); end
            n_cmp++; if (fwd_rt_e !== fe_rt) begin n_err++; $display("FAIL rnd_fwd_rt_e c%0d: got %0d want %0d", i, fwd_rt_e, fe_rt); end
            n_cmp++; if (stall_cnt !== m_cnt) begin n_err++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", i, stall_cnt, m_cnt); end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_load_branch();
        test_alu_fwd();
        test_jal_jr();
        test_zero_reg();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
